// File: rtl/div_unit.sv
// div_unit: multicycle 32-bit restoring divider, quotient to lo, remainder to hi.
// Optional DIV_UNSIGNED_EN adds the isUnsigned port for DIVU.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        divControl,
`ifdef DIV_UNSIGNED_EN
  input  logic        isUnsigned,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divDone,
  output logic        div0,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    DONE,
    ZERO
  } state_t;

  state_t      state;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] shreg;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic        phase;

  logic        uns;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        nbit;
  logic [32:0] remsh;
  logic        ge;
  logic [31:0] sub;
  logic [31:0] rem_nx;

`ifdef DIV_UNSIGNED_EN
  assign uns = isUnsigned;
`else
  assign uns = 1'b0;
`endif

  assign a_abs = (!uns && a[31]) ? -a : a;
  assign b_abs = (!uns && b[31]) ? -b : b;

  // Dividend bits are fed MSB-first from the latched magnitude.
  assign nbit   = a_mag[~cnt];
  assign remsh  = {shreg[63:32], nbit};
  assign ge     = remsh >= {1'b0, b_mag};
  assign sub    = remsh[31:0] - b_mag;
  assign rem_nx = ge ? sub : remsh[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_mag   <= '0;
      b_mag   <= '0;
      shreg   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      phase   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      divDone <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          divDone <= 1'b0;
          div0    <= 1'b0;
          if (divControl) begin
            busy <= 1'b1;
            if (b == 32'd0) begin
              state <= ZERO;
              div0  <= 1'b1;
            end else begin
              state <= CALC;
              a_mag <= a_abs;
              b_mag <= b_abs;
              neg_q <= !uns && (a[31] ^ b[31]);
              neg_r <= !uns && a[31];
              shreg <= '0;
              cnt   <= '0;
              phase <= 1'b0;
            end
          end
        end
        CALC: begin
          shreg <= {rem_nx, shreg[30:0], ge};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          // First cycle applies signs, second commits to hi/lo.
          if (!phase) begin
            shreg[63:32] <= neg_r ? -shreg[63:32] : shreg[63:32];
            shreg[31:0]  <= neg_q ? -shreg[31:0] : shreg[31:0];
            phase        <= 1'b1;
          end else begin
            hi      <= shreg[63:32];
            lo      <= shreg[31:0];
            divDone <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          divDone <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        ZERO: begin
          div0  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit.
// Define DIV_UNSIGNED_EN to also exercise the DIVU path.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        divControl;
  logic        isUnsigned;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divDone;
  logic        div0;
  logic        busy;

  int n_chk;
  int n_fail;

  div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
`ifdef DIV_UNSIGNED_EN
    .isUnsigned (isUnsigned),
`endif
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .divDone    (divDone),
    .div0       (div0),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; start is sampled at the next posedge.
  task automatic start(input logic [31:0] av, input logic [31:0] bv,
                       input logic uv);
    a          = av;
    b          = bv;
    isUnsigned = uv;
    divControl = 1'b1;
    @(negedge clk);
    divControl = 1'b0;
    a          = 32'h1234_5678;
    b          = 32'h0000_0003;
    isUnsigned = 1'b0;
  endtask

  // Returns the cycle index after the start edge at which a pulse appeared.
  task automatic wait_end(output int cyc, output logic dz);
    cyc = 0;
    dz  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) check("busy_first", {31'd0, busy}, 32'd1);
      if (divDone && div0) check("both_pulses", 32'd1, 32'd0);
      if (divDone || div0) begin
        cyc = k;
        dz  = div0;
        break;
      end
      @(negedge clk);
    end
    if (cyc == 0) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] av,
                     input logic [31:0] bv, input logic uv,
                     input logic [31:0] elo, input logic [31:0] ehi);
    int   cyc;
    logic dz;
    start(av, bv, uv);
    wait_end(cyc, dz);
    check({tag, "_lat"}, cyc, 32'd35);
    check({tag, "_div0"}, {31'd0, dz}, 32'd0);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulse_len"}, {31'd0, divDone}, 32'd0);
  endtask

  initial begin
    int   cyc;
    logic dz;
    int   seen;
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    divControl = 1'b0;
    isUnsigned = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, divDone}, 32'd0);
    check("rst_div0", {31'd0, div0}, 32'd0);
    reset = 1'b0;

    run("pos", 32'd7, 32'd2, 1'b0, 32'd3, 32'd1);
    run("nega", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("negb", 32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1);
    run("minv", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0);
    run("big", 32'd1000000, 32'd7, 1'b0, 32'd142857, 32'd1);
    run("prev", 32'd41, 32'd6, 1'b0, 32'd6, 32'd5);

    start(32'd99, 32'd0, 1'b0);
    wait_end(cyc, dz);
    check("z_lat", cyc, 32'd1);
    check("z_flag", {31'd0, dz}, 32'd1);
    check("z_hi", hi, 32'd5);
    check("z_lo", lo, 32'd6);
    @(negedge clk);
    check("z_busy_after", {31'd0, busy}, 32'd0);
    check("z_pulse_len", {31'd0, div0}, 32'd0);
    check("z_no_done", {31'd0, divDone}, 32'd0);

    start(32'd7, 32'd2, 1'b0);
    repeat (8) @(negedge clk);
    a          = 32'd100;
    b          = 32'd3;
    divControl = 1'b1;
    @(negedge clk);
    divControl = 1'b0;
    seen = 0;
    for (int k = 10; k <= 34; k++) begin
      if (divDone) seen++;
      @(negedge clk);
    end
    check("ign_early", seen, 32'd0);
    check("ign_done", {31'd0, divDone}, 32'd1);
    check("ign_lo", lo, 32'd3);
    check("ign_hi", hi, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (divDone || busy) seen++;
    end
    check("ign_not_queued", seen, 32'd0);

    start(32'd100, 32'd7, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (divDone) seen++;
    end
    check("abort_no_done", seen, 32'd0);

    reset      = 1'b1;
    divControl = 1'b1;
    a          = 32'd9;
    b          = 32'd0;
    @(negedge clk);
    reset      = 1'b0;
    divControl = 1'b0;
    check("rst_wins_busy", {31'd0, busy}, 32'd0);
    check("rst_wins_div0", {31'd0, div0}, 32'd0);

    run("b2b1", 32'd20, 32'd3, 1'b0, 32'd6, 32'd2);
    run("b2b2", 32'hFFFF_FFEC, 32'd3, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFE);

`ifdef DIV_UNSIGNED_EN
    run("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1);
`endif
    run("divs", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
